// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Provides the FSM state enum, row/word sizes and the row-to-bit mapping.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    FINISH
  } tt_state_e;

  localparam int TT_ROWS = 8;
  localparam int TT_W    = 8;

  // Row k lands in word bit 7-k: row 000 is the MSB.
  function automatic logic [2:0] row_bit(input logic [2:0] k);
    return 3'd7 - k;
  endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synchronised out).
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps in1..in3 over all 8 rows, samples gate_out per row and
// compares the captured truth-table word against a latched expected word.
// Ports: clk, rst_n, start, abort, expected[7:0], gate_out ->
//        in1/in2/in3, busy, done, table_q[7:0], match, mismatch_mask[7:0].
// Macro GATE_SYNC_EN: synchronise gate_out with 2 flops and hold
// each row 2 extra cycles.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  expected,
  input  logic        gate_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        busy,
  output logic        done,
  output logic [7:0]  table_q,
  output logic        match,
  output logic [7:0]  mismatch_mask
);

  logic gate_s;

`ifdef GATE_SYNC_EN
  localparam int HOLD = SETTLE_CYCLES + 2;

  tt_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gate_out),
    .q     (gate_s)
  );
`else
  localparam int HOLD = SETTLE_CYCLES;

  assign gate_s = gate_out;
`endif

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);
  localparam logic [2:0]       LAST   = 3'(TT_ROWS - 1);

  tt_state_e        state;
  logic [2:0]       row;
  logic [CNT_W-1:0] cnt;
  logic [TT_W-1:0]  exp_r;
  logic [TT_W-1:0]  shadow;

  // A row is APPLY for HOLD-1 cycles then one SAMPLE cycle;
  // a one-cycle window goes straight to SAMPLE.
  tt_state_e row_st;
  assign row_st = (RELOAD == '0) ? SAMPLE : APPLY;

  assign {in1, in2, in3} = busy ? row : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= '0;
      cnt           <= '0;
      exp_r         <= '0;
      shadow        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      table_q       <= '0;
      match         <= 1'b0;
      mismatch_mask <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_r <= expected;
            row   <= '0;
            cnt   <= RELOAD;
            busy  <= 1'b1;
            state <= row_st;
          end
        end
        APPLY: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
              state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            shadow[row_bit(row)] <= gate_s;
            if (row == LAST) begin
              state <= FINISH;
            end else begin
              row   <= row + 1'b1;
              cnt   <= RELOAD;
              state <= row_st;
            end
          end
        end
        FINISH: begin
          table_q       <= shadow;
          match         <= (shadow == exp_r);
          mismatch_mask <= shadow ^ exp_r;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a behavioural gate
// model driven by a truth-table word.
module tb_truth_table_sweeper;

`ifdef GATE_SYNC_EN
  localparam int HOLD = 6;
`else
  localparam int HOLD = 4;
`endif
  localparam int LAT = 8 * HOLD + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       gate_out;
  logic       in1, in2, in3;
  logic       busy, done, match;
  logic [7:0] table_q, mismatch_mask;
  logic [7:0] model = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  int lat, ndone, rowerr;

  always #5 clk = ~clk;

  assign gate_out = model[3'd7 - {in1, in2, in3}];

  truth_table_sweeper #(
    .SETTLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .expected      (expected),
    .gate_out      (gate_out),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .busy          (busy),
    .done          (done),
    .table_q       (table_q),
    .match         (match),
    .mismatch_mask (mismatch_mask)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; start is seen on the next edge.
  task automatic start_pulse(input logic [7:0] e, input bit with_abort);
    expected = e;
    start    = 1'b1;
    abort    = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Cycle c counts rising edges after the accepting edge.
  task automatic run(input bit repulse, output int l, output int nd,
                     output int re);
    l  = -1;
    nd = 0;
    re = 0;
    if (busy !== 1'b1 || {in1, in2, in3} !== 3'b000) re++;
    for (int c = 1; c <= LAT + 6; c++) begin
      @(posedge clk);
      #1;
      start = repulse && (c == 5 || c == 20);
      if (repulse && c == 7) expected = ~expected;
      if (c < 8 * HOLD) begin
        if (busy !== 1'b1 || {in1, in2, in3} !== 3'(c / HOLD)) re++;
      end
      if (done === 1'b1) begin
        nd++;
        if (l < 0) l = c;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in", {in1, in2, in3}, 0);
    chk("rst_table", table_q, 8'h00);
    chk("rst_match", match, 0);
    chk("rst_mask", mismatch_mask, 8'h00);
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: matching sweep
    model = 8'hAE;
    start_pulse(8'hAE, 1'b0);
    run(1'b0, lat, ndone, rowerr);
    chk("t1_lat", lat, LAT);
    chk("t1_ndone", ndone, 1);
    chk("t1_rows", rowerr, 0);
    chk("t1_busy", busy, 0);
    chk("t1_table", table_q, 8'hAE);
    chk("t1_match", match, 1);
    chk("t1_mask", mismatch_mask, 8'h00);

    // 2: expected differs in bit 0
    start_pulse(8'hAF, 1'b0);
    run(1'b0, lat, ndone, rowerr);
    chk("t2_lat", lat, LAT);
    chk("t2_table", table_q, 8'hAE);
    chk("t2_match", match, 0);
    chk("t2_mask", mismatch_mask, 8'h01);

    // 3: abort at cycle 10
    start_pulse(8'hAE, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("t3_busy", busy, 0);
    chk("t3_in", {in1, in2, in3}, 0);
    chk("t3_done", done, 0);
    ndone = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("t3_nodone", ndone, 0);
    chk("t3_table", table_q, 8'hAE);
    chk("t3_match", match, 0);
    chk("t3_mask", mismatch_mask, 8'h01);

    // 4: start re-pulsed and expected changed mid-sweep
    model = 8'h3C;
    start_pulse(8'h3C, 1'b0);
    run(1'b1, lat, ndone, rowerr);
    chk("t4_lat", lat, LAT);
    chk("t4_ndone", ndone, 1);
    chk("t4_rows", rowerr, 0);
    chk("t4_table", table_q, 8'h3C);
    chk("t4_match", match, 1);

    // 5: async reset at cycle 12
    model = 8'hAE;
    start_pulse(8'hAE, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_in", {in1, in2, in3}, 0);
    chk("t5_table", table_q, 8'h00);
    chk("t5_match", match, 0);
    chk("t5_mask", mismatch_mask, 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_pulse(8'hAE, 1'b0);
    run(1'b0, lat, ndone, rowerr);
    chk("t5_lat", lat, LAT);
    chk("t5_rtable", table_q, 8'hAE);
    chk("t5_rmatch", match, 1);

    // 6: start with abort in IDLE, word 5C
    model = 8'h5C;
    start_pulse(8'h5C, 1'b1);
    run(1'b0, lat, ndone, rowerr);
    chk("t6_lat", lat, LAT);
    chk("t6_rows", rowerr, 0);
    chk("t6_table", table_q, 8'h5C);
    chk("t6_match", match, 1);
    chk("t6_mask", mismatch_mask, 8'h00);

    // 7: all-zero gate against all-ones expectation
    model = 8'h00;
    start_pulse(8'hFF, 1'b0);
    run(1'b0, lat, ndone, rowerr);
    chk("t7_table", table_q, 8'h00);
    chk("t7_match", match, 0);
    chk("t7_mask", mismatch_mask, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
